// File: rtl/h_next_add_pkg.sv
// Shared FP16 constants, SSM stage state encodings and the FP16 adder datapath.
package h_next_add_pkg;

  localparam int DW_FP16 = 16;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // Sequencing shared by the multiply, add and y stages.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // IEEE half-precision add, round-to-nearest-even, subnormals handled,
  // NaN/inf propagate and inf + (-inf) yields a quiet NaN.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, res;
    logic [5:0]  ex, ey, e, d;
    logic [13:0] mx, my, sm, m;
    logic [14:0] s;
    logic [11:0] mr;
    logic        sticky, rnd, a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
    res = FP16_ZERO;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      res = FP16_QNAN;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else begin
      // x is the operand of larger magnitude; its sign wins.
      if (a[14:0] >= b[14:0]) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      ex = (x[14:10] == 5'h00) ? 6'd1 : {1'b0, x[14:10]};
      ey = (y[14:10] == 5'h00) ? 6'd1 : {1'b0, y[14:10]};
      mx = {(x[14:10] != 5'h00), x[9:0], 3'b000};
      my = {(y[14:10] != 5'h00), y[9:0], 3'b000};
      d  = ex - ey;
      // Align the smaller operand; bits shifted out collapse into a sticky bit.
      if (d > 6'd13) begin
        sm     = 14'h0000;
        sticky = (my != 14'h0000);
      end else begin
        sm     = my >> d;
        sticky = ((sm << d) != my);
      end
      sm = sm | {13'h0000, sticky};
      if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, sm};
      else                s = {1'b0, mx} - {1'b0, sm};
      e = ex;
      if (s[14]) begin
        m = s[14:1] | {13'h0000, s[0]};
        e = ex + 6'd1;
      end else begin
        m = s[13:0];
        // Renormalise after cancellation, stopping at the subnormal exponent.
        for (int i = 0; i < 13; i++) begin
          if (!m[13] && (e > 6'd1)) begin
            m = m << 1;
            e = e - 6'd1;
          end
        end
      end
      rnd = m[2] & (m[1] | m[0] | m[3]);
      mr  = {1'b0, m[13:3]} + {11'h000, rnd};
      if (mr[11]) begin
        mr = mr >> 1;
        e  = e + 6'd1;
      end
      if (s == 15'h0000)    res = {x[15] & y[15], 15'h0000};
      else if (e >= 6'd31)  res = {x[15], 5'h1F, 10'h000};
      else                  res = {x[15], (mr[10] ? e[4:0] : 5'h00), mr[9:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/h_next_add_fp16_add.sv
// Pipelined FP16 adder lane: the sum is formed in the first stage and carried,
// with its valid, through A_LAT register stages in total.
module fp16_add_wrapper
  import h_next_add_pkg::*;
#(
  parameter int A_LAT = 5
) (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        valid_in,
  output logic [15:0] result,
  output logic        valid_out
);

  logic [15:0]      res_r [A_LAT];
  logic [A_LAT-1:0] vld_r;

  // Compute in stage 0, then delay so valid_out trails valid_in by A_LAT cycles.
  always_ff @(posedge clk) begin
    res_r[0] <= fp16_add(a, b);
    vld_r[0] <= valid_in;
    for (int s = 1; s < A_LAT; s++) begin
      res_r[s] <= res_r[s-1];
      vld_r[s] <= vld_r[s-1];
    end
  end

  assign result    = res_r[A_LAT-1];
  assign valid_out = vld_r[A_LAT-1];

endmodule

// File: rtl/h_next_add.sv
// SSM state update, add stage: h_next = h_mul + dBx element-wise in FP16 using
// PAR adder lanes, sequenced IDLE -> CALC -> FLUSH -> DONE with a done/ack handshake.
module h_next_add
  import h_next_add_pkg::*;
#(
  parameter int B     = 1,
  parameter int H     = 4,
  parameter int P     = 4,
  parameter int N     = 4,
  parameter int DW    = DW_FP16,
  parameter int A_LAT = 5,
  parameter int PAR   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    ack,
  input  logic [B*H*P*N*DW-1:0]   h_mul_flat,
  input  logic [B*H*P*N*DW-1:0]   dBx_flat,
  output logic [B*H*P*N*DW-1:0]   h_next_flat,
  output logic                    busy,
  output logic                    done
);

  localparam int TOTAL = B * H * P * N;
  localparam int KW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BW    = (B > 1) ? $clog2(B) : 1;
  localparam int HW    = (H > 1) ? $clog2(H) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int FW    = $clog2(A_LAT + 1);

  logic [1:0]    state_r, state_nxt_s;
  logic [BW-1:0] b_r;
  logic [HW-1:0] h_r;
  logic [PW-1:0] p_r;
  logic [NW-1:0] n_r;
  logic [FW-1:0] flush_r;
  logic          busy_r, done_r;
  logic          n_wrap_s, last_beat_s;

  logic [DW-1:0] h_mul_arr_s [TOTAL];
  logic [DW-1:0] dbx_arr_s   [TOTAL];
  logic [DW-1:0] h_next_r    [TOTAL];

  logic [KW-1:0]    base_s;
  logic [KW-1:0]    lane_k_s [PAR];
  logic [DW-1:0]    lane_a_s [PAR];
  logic [DW-1:0]    lane_b_s [PAR];
  logic [PAR-1:0]   lane_v_s;
  logic [DW-1:0]    sum_s    [PAR];
  logic [PAR-1:0]   vout_s;
  logic [PAR-1:0]   wr_s;
  logic [KW-1:0]    k_dly_r  [PAR][A_LAT];
  logic [A_LAT-1:0] v_dly_r  [PAR];

  for (genvar g = 0; g < TOTAL; g++) begin : g_view
    assign h_mul_arr_s[g]           = h_mul_flat[g*DW +: DW];
    assign dbx_arr_s[g]             = dBx_flat[g*DW +: DW];
    assign h_next_flat[g*DW +: DW]  = h_next_r[g];
  end

  assign n_wrap_s    = (int'(n_r) + PAR) >= N;
  assign last_beat_s = (b_r == BW'(B - 1)) && (h_r == HW'(H - 1)) &&
                       (p_r == PW'(P - 1)) && n_wrap_s;
  assign busy = busy_r;
  assign done = done_r;

  // Next-state logic for the IDLE/CALC/FLUSH/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = start ? ST_CALC : ST_IDLE;
      ST_CALC:  state_nxt_s = last_beat_s ? ST_FLUSH : ST_CALC;
      ST_FLUSH: state_nxt_s = (flush_r == FW'(A_LAT)) ? ST_DONE : ST_FLUSH;
      ST_DONE:  state_nxt_s = ack ? ST_IDLE : ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, element counters, flush counter and the registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      b_r     <= '0;
      h_r     <= '0;
      p_r     <= '0;
      n_r     <= '0;
      flush_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FLUSH);
      done_r  <= (state_nxt_s == ST_DONE);
      flush_r <= (state_r == ST_FLUSH) ? flush_r + FW'(1) : FW'(0);
      if ((state_r == ST_IDLE) && start) begin
        b_r <= '0;
        h_r <= '0;
        p_r <= '0;
        n_r <= '0;
      end else if (state_r == ST_CALC) begin
        if (!n_wrap_s) begin
          n_r <= n_r + NW'(PAR);
        end else begin
          n_r <= '0;
          if (p_r != PW'(P - 1)) begin
            p_r <= p_r + PW'(1);
          end else begin
            p_r <= '0;
            if (h_r != HW'(H - 1)) begin
              h_r <= h_r + HW'(1);
            end else begin
              h_r <= '0;
              b_r <= (b_r == BW'(B - 1)) ? BW'(0) : b_r + BW'(1);
            end
          end
        end
      end else begin
        n_r <= n_r;
      end
    end
  end

  // Per-lane flat index, in-range mask and operand fetch for the current beat.
  always_comb begin
    base_s = KW'(((int'(b_r) * H + int'(h_r)) * P + int'(p_r)) * N + int'(n_r));
    for (int i = 0; i < PAR; i++) begin
      lane_k_s[i] = base_s + KW'(i);
      lane_v_s[i] = (state_r == ST_CALC) && ((int'(n_r) + i) < N);
      lane_a_s[i] = lane_v_s[i] ? h_mul_arr_s[lane_k_s[i]] : FP16_ZERO;
      lane_b_s[i] = lane_v_s[i] ? dbx_arr_s[lane_k_s[i]]   : FP16_ZERO;
      // Reset-cleared valids gate off anything the unreset adder pipes emit.
      wr_s[i]     = vout_s[i] && v_dly_r[i][A_LAT-1] &&
                    ((state_r == ST_CALC) || (state_r == ST_FLUSH));
    end
  end

  for (genvar i = 0; i < PAR; i++) begin : g_lane
    fp16_add_wrapper #(.A_LAT(A_LAT)) u_add (
      .clk       (clk),
      .a         (lane_a_s[i]),
      .b         (lane_b_s[i]),
      .valid_in  (lane_v_s[i]),
      .result    (sum_s[i]),
      .valid_out (vout_s[i])
    );
  end

  // Index/valid delay line kept in step with each adder's latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAR; i++) begin
        v_dly_r[i] <= '0;
        for (int s = 0; s < A_LAT; s++) k_dly_r[i][s] <= '0;
      end
    end else begin
      for (int i = 0; i < PAR; i++) begin
        k_dly_r[i][0] <= lane_k_s[i];
        v_dly_r[i][0] <= lane_v_s[i];
        for (int s = 1; s < A_LAT; s++) begin
          k_dly_r[i][s] <= k_dly_r[i][s-1];
          v_dly_r[i][s] <= v_dly_r[i][s-1];
        end
      end
    end
  end

  // Result writeback: each lane writes its sum to the index that travelled with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < TOTAL; g++) h_next_r[g] <= '0;
    end else begin
      for (int i = 0; i < PAR; i++) begin
        if (wr_s[i]) h_next_r[k_dly_r[i][A_LAT-1]] <= sum_s[i];
      end
    end
  end

endmodule

// File: tb/tb_h_next_add.sv
// Directed bench for h_next_add: a default instance (N=4, PAR=16) and a
// partial-beat instance (N=6, PAR=4), with expected words queued at launch.
module tb_h_next_add;

  localparam int DW = 16;
  localparam int T0 = 64;
  localparam int T1 = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, ack0 = 1'b0, busy0, done0;
  logic start1 = 1'b0, ack1 = 1'b0, busy1, done1;
  logic [T0*DW-1:0] hm_flat0 = '0, db_flat0 = '0, hn_flat0;
  logic [T1*DW-1:0] hm_flat1 = '0, db_flat1 = '0, hn_flat1;

  h_next_add dut0 (
    .clk(clk), .rst(rst), .start(start0), .ack(ack0),
    .h_mul_flat(hm_flat0), .dBx_flat(db_flat0), .h_next_flat(hn_flat0),
    .busy(busy0), .done(done0)
  );

  h_next_add #(.N(6), .PAR(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ack(ack1),
    .h_mul_flat(hm_flat1), .dBx_flat(db_flat1), .h_next_flat(hn_flat1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic nan_only; logic [15:0] val; } exp_t;
  exp_t sb_q[$];

  logic [15:0] hm [T1];
  logic [15:0] db [T1];
  logic [15:0] ex [T1];
  logic        nanx [T1];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] int2fp(input int v);
    int msb = 0;
    if (v == 0) return 16'h0000;
    for (int i = 0; i < 16; i++) if (v[i]) msb = i;
    return 16'(((msb + 15) << 10) | ((v << (10 - msb)) & 32'h3FF));
  endfunction

  function automatic logic [T0*DW-1:0] exp_flat0();
    logic [T0*DW-1:0] f;
    for (int g = 0; g < T0; g++) f[g*DW +: DW] = ex[g];
    return f;
  endfunction

  task automatic fill(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    for (int g = 0; g < T1; g++) begin
      hm[g] = a; db[g] = b; ex[g] = s; nanx[g] = 1'b0;
    end
  endtask

  task automatic drive(input bit sel);
    for (int g = 0; g < (sel ? T1 : T0); g++) begin
      if (sel) begin hm_flat1[g*DW +: DW] = hm[g]; db_flat1[g*DW +: DW] = db[g]; end
      else     begin hm_flat0[g*DW +: DW] = hm[g]; db_flat0[g*DW +: DW] = db[g]; end
    end
  endtask

  task automatic push_expect(input bit sel);
    for (int g = 0; g < (sel ? T1 : T0); g++) sb_q.push_back('{nan_only: nanx[g], val: ex[g]});
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
  endtask

  // The cycle in which start is high counts as cycle 1.
  task automatic wait_done(input bit sel, input int exp_lat, input int exp_busy, input string tag);
    int cyc = 1;
    int bcnt = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      cyc++;
      if (sel ? done1 : done0) seen = 1'b1;
      else if (sel ? busy1 : busy0) bcnt++;
    end
    check({tag, "_latency"}, seen ? cyc : 0, exp_lat);
    check({tag, "_busy_cycles"}, bcnt, exp_busy);
  endtask

  task automatic drain(input bit sel, input string tag);
    exp_t e;
    logic [15:0] w;
    for (int g = 0; g < (sel ? T1 : T0); g++) begin
      e = sb_q.pop_front();
      w = sel ? hn_flat1[g*DW +: DW] : hn_flat0[g*DW +: DW];
      if (e.nan_only) check($sformatf("%s_nan[%0d]", tag, g), (w[14:10] == 5'h1F) && (w[9:0] != 10'h000), 1);
      else            check($sformatf("%s[%0d]", tag, g), w, e.val);
    end
  endtask

  task automatic do_ack(input bit sel, input string tag);
    @(negedge clk);
    if (sel) ack1 = 1'b1; else ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0; ack1 = 1'b0;
    check({tag, "_done_after_ack"}, sel ? done1 : done0, 0);
  endtask

  task automatic run0(input string tag);
    drive(1'b0);
    push_expect(1'b0);
    pulse_start(1'b0);
    wait_done(1'b0, 24, 22, tag);
    drain(1'b0, tag);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_done", done0, 0);
    check("rst_busy", busy0, 0);
    check("rst_words_zero", hn_flat0 === '0, 1);
    rst = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0 everywhere, then the DONE handshake.
    fill(16'h3C00, 16'h4000, 16'h4200);
    run0("add_1p0_2p0");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_done", done0, 1);
      check("hold_stable", hn_flat0 === exp_flat0(), 1);
    end
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("start_in_done_done", done0, 1);
    check("start_in_done_busy", busy0, 0);
    @(negedge clk); ack0 = 1'b1; start0 = 1'b1;
    @(negedge clk); ack0 = 1'b0; start0 = 1'b0;
    check("ack_done_low", done0, 0);
    check("ack_start_ignored_busy", busy0, 0);
    @(negedge clk);
    check("idle_stays_busy", busy0, 0);
    check("idle_retains", hn_flat0 === exp_flat0(), 1);

    // 0.5 + -1.0, then only element 7 changed to 1.0 + -1.0.
    fill(16'h3800, 16'hBC00, 16'hB800);
    run0("add_neg");
    do_ack(1'b0, "add_neg");
    hm[7] = 16'h3C00; db[7] = 16'hBC00; ex[7] = 16'h0000;
    run0("elem7_cancel");
    do_ack(1'b0, "elem7_cancel");

    // Specials and round-to-nearest-even ties.
    fill(16'h3C00, 16'h4000, 16'h4200);
    hm[0] = 16'h7C00; db[0] = 16'h3C00; ex[0] = 16'h7C00;
    hm[1] = 16'h7C00; db[1] = 16'hFC00; nanx[1] = 1'b1;
    hm[2] = 16'hFC00; db[2] = 16'h3C00; ex[2] = 16'hFC00;
    hm[3] = 16'h3C00; db[3] = 16'h1000; ex[3] = 16'h3C00;
    hm[4] = 16'h3C01; db[4] = 16'h1000; ex[4] = 16'h3C02;
    run0("specials");
    do_ack(1'b0, "specials");

    // Partial last beat: N=6, PAR=4, h_next[g] = g + 1.
    for (int g = 0; g < T1; g++) begin
      hm[g] = int2fp(g); db[g] = 16'h3C00; ex[g] = int2fp(g + 1); nanx[g] = 1'b0;
    end
    drive(1'b1);
    push_expect(1'b1);
    pulse_start(1'b1);
    wait_done(1'b1, 40, 38, "partial");
    drain(1'b1, "partial");
    do_ack(1'b1, "partial");

    // Reset during CALC, then a clean run.
    fill(16'h4000, 16'h4000, 16'h4400);
    drive(1'b0);
    pulse_start(1'b0);
    @(negedge clk); start0 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", busy0, 1);
    rst = 1'b0;
    #1;
    check("abort_done", done0, 0);
    check("abort_busy", busy0, 0);
    check("abort_words_zero", hn_flat0 === '0, 1);
    @(negedge clk); rst = 1'b1;
    repeat (8) @(negedge clk);
    check("no_stale_writes", hn_flat0 === '0, 1);
    check("post_abort_idle", busy0, 0);
    run0("after_abort");
    do_ack(1'b0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
